pkt_build_ctrl: RTL and testbench

- Sequences one packet-build transaction end to end.
- Issues a burst read of the input payload from the in-memory and extracts payload bytes according to the merge mode (data_sel).
- Computes CRC8 over the payload, then issues a burst write of the output packet to the out-memory: 2-byte header, payload, CRC byte.
- Sits between the register/start logic and the shared read/write memory channels that the packet datapath uses.

---
 rtl/pkt_build_ctrl_if.sv | 40 ++++
 rtl/pkt_build_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pkt_build_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_build_ctrl_if.sv
// Read/write burst memory channels shared by the packet datapath.
// master = transaction controller, slave = memory side.
interface pkt_build_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              rlast;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arlen, arvalid, input arready,
    input  rdata, rvalid, rlast, output rready,
    output awaddr, awlen, awvalid, input awready,
    output wdata, wvalid, wlast, input wready,
    input  bvalid, output bready
  );

  modport slave (
    input  araddr, arlen, arvalid, output arready,
    output rdata, rvalid, rlast, input rready,
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wvalid, wlast, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/pkt_build_ctrl.sv
// Packet build sequencer: burst-read payload, CRC8 it, burst-write {hdr0,hdr1,payload,crc}.
// Latency is set by the memory handshakes; every valid holds with stable payload until its ready.
module pkt_build_ctrl #(
  parameter int         ADDR_W    = 32,
  parameter logic [7:0] HDR_BYTE1 = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        byte_cnt,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] out_addr,
  pkt_build_ctrl_if.master  mem,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, sel_q;
  logic [ADDR_W-1:0] in_addr_q, out_addr_q;
  logic [7:0]        buf_q [16];
  logic [7:0]        buf_d [16];
  logic [7:0]        crc_q, crc_d;
  logic [4:0]        rbeat_q;
  logic [2:0]        wbeat_q;
  logic              rerr_seen_q, err_q;
  logic [4:0]        len, rbeats, wbeats, n_w;
  logic [2:0]        kbytes;
  logic [6:0]        base, idx;
  logic [31:0]       wdata_c;
  logic              rd_hs, early_last, late_last, wlast_c;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  always_comb begin
    len    = {1'b0, cnt_q} + 5'd1;
    wbeats = ({1'b0, cnt_q} + 5'd7) >> 2;
    case (sel_q[1:0])
      2'd0:    begin kbytes = 3'd1; rbeats = len;               end
      2'd1:    begin kbytes = 3'd2; rbeats = (len + 5'd1) >> 1; end
      default: begin kbytes = 3'd4; rbeats = (len + 5'd3) >> 2; end
    endcase
  end

  assign rd_hs      = (state_q == RD_DATA) && mem.rvalid;
  assign base       = 7'(rbeat_q) * 7'(kbytes);
  // rbeat_q saturates at 16 so rbeat_q+1 never wraps in these compares
  assign early_last = rd_hs && mem.rlast && ((rbeat_q + 5'd1) < rbeats);
  assign late_last  = rd_hs && !mem.rlast && ((rbeat_q + 5'd1) == rbeats);
  assign wlast_c    = ({2'b00, wbeat_q} == (wbeats - 5'd1));

  // Bytes of the current beat into the buffer; a short burst folds the missing zero bytes into the CRC
  always_comb begin
    buf_d = buf_q;
    crc_d = crc_q;
    idx   = '0;
    for (int j = 0; j < 4; j++) begin
      idx = base + 7'(j);
      if ((3'(j) < kbytes) && (idx < 7'(len))) begin
        buf_d[idx[3:0]] = mem.rdata[8*j +: 8];
        crc_d           = crc8_step(crc_d, mem.rdata[8*j +: 8]);
      end
    end
    if (early_last) begin
      for (int i = 0; i < 16; i++) begin
        if ((7'(i) >= (base + 7'(kbytes))) && (7'(i) < 7'(len))) crc_d = crc8_step(crc_d, 8'h00);
      end
    end
  end

  always_comb begin
    wdata_c = '0;
    n_w     = '0;
    for (int b = 0; b < 4; b++) begin
      n_w = {wbeat_q, 2'b00} + 5'(b);
      if (n_w == 5'd0)              wdata_c[8*b +: 8] = {sel_q, cnt_q};
      else if (n_w == 5'd1)         wdata_c[8*b +: 8] = HDR_BYTE1;
      else if (n_w < (len + 5'd2))  wdata_c[8*b +: 8] = buf_q[4'(n_w - 5'd2)];
      else if (n_w == (len + 5'd2)) wdata_c[8*b +: 8] = crc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awvalid = 1'b0;
    mem.wvalid  = 1'b0;
    mem.wlast   = 1'b0;
    mem.bready  = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE:    if (start && (data_sel <= 4'd2)) state_d = RD_ADDR;
      RD_ADDR: begin
        mem.arvalid = 1'b1;
        if (mem.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        mem.rready = 1'b1;
        if (mem.rvalid && mem.rlast) state_d = WR_ADDR;
      end
      WR_ADDR: begin
        mem.awvalid = 1'b1;
        if (mem.awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        mem.wvalid = 1'b1;
        mem.wlast  = wlast_c;
        if (mem.wready && wlast_c) state_d = WR_RESP;
      end
      WR_RESP: begin
        mem.bready = 1'b1;
        if (mem.bvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      buf_q       <= '{default: 8'h00};
      crc_q       <= '0;
      rbeat_q     <= '0;
      wbeat_q     <= '0;
      rerr_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if ((state_q == IDLE) && start) begin
        if (data_sel > 4'd2) begin
          err_q <= 1'b1;
        end else begin
          cnt_q       <= byte_cnt;
          sel_q       <= data_sel;
          in_addr_q   <= in_addr;
          out_addr_q  <= out_addr;
          buf_q       <= '{default: 8'h00};
          crc_q       <= '0;
          rbeat_q     <= '0;
          wbeat_q     <= '0;
          rerr_seen_q <= 1'b0;
        end
      end
      if (rd_hs) begin
        buf_q <= buf_d;
        crc_q <= crc_d;
        if (rbeat_q != 5'd16) rbeat_q <= rbeat_q + 5'd1;
        if ((early_last || late_last) && !rerr_seen_q) begin
          err_q       <= 1'b1;
          rerr_seen_q <= 1'b1;
        end
      end
      if ((state_q == WR_DATA) && mem.wready) wbeat_q <= wbeat_q + 3'd1;
    end
  end

  assign mem.araddr = in_addr_q;
  assign mem.arlen  = {3'b000, rbeats - 5'd1};
  assign mem.awaddr = out_addr_q;
  assign mem.awlen  = {3'b000, wbeats - 5'd1};
  assign mem.wdata  = (state_q == WR_DATA) ? wdata_c : 32'h0;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_pkt_build_ctrl.sv
// Bench for pkt_build_ctrl: vector table, hand-written corner sequences and a randomized
// run against a byte-stream reference model, all driven through a simple memory slave.
module tb_pkt_build_ctrl;

  typedef struct packed {
    logic [31:0]      araddr;
    logic [7:0]       arlen;
    logic [31:0]      awaddr;
    logic [7:0]       awlen;
    int               wn;
    logic [4:0][31:0] w;
    int               errs;
  } exp_t;

  typedef struct packed {
    logic [3:0]       sel;
    logic [3:0]       cnt;
    logic [31:0]      ia;
    logic [31:0]      oa;
    logic [3:0][31:0] rw;
    int               rl;
    int               dly;
    exp_t             e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  byte_cnt = '0;
  logic [3:0]  data_sel = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] out_addr = '0;
  logic        busy, done, err;

  pkt_build_ctrl_if #(.ADDR_W(32)) bus();

  pkt_build_ctrl #(.ADDR_W(32), .HDR_BYTE1(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_cnt(byte_cnt), .data_sel(data_sel),
    .in_addr(in_addr), .out_addr(out_addr), .mem(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_pass = 0;
  int    done_cnt = 0;
  int    err_cnt = 0;
  string cur_tag = "reset";

  logic [31:0] rwords [32];
  logic [31:0] got_araddr, got_awaddr;
  logic [7:0]  got_arlen, got_awlen;
  logic [31:0] got_w [8];
  logic [7:0]  got_wl;
  int          got_wn;

  always @(negedge clk) begin
    #2;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s %s: got %0h, expected %0h", cur_tag, name, act, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [3:0] sel, input logic [3:0] cnt,
                                 input logic [31:0] ia, input logic [31:0] oa, input int rl);
    exp_t       e;
    int         L, k, R, got, W;
    logic [7:0] pl [16];
    logic [7:0] s [24];
    logic [7:0] c;
    L   = int'(cnt) + 1;
    k   = (sel == 4'd0) ? 1 : (sel == 4'd1) ? 2 : 4;
    R   = (L + k - 1) / k;
    got = (rl + 1 < R) ? rl + 1 : R;
    for (int i = 0; i < 16; i++) pl[i] = 8'h00;
    for (int i = 0; i < L; i++) if (i / k < got) pl[i] = 8'(rwords[i / k] >> (8 * (i % k)));
    c = 8'h00;
    for (int i = 0; i < L; i++) begin
      c = c ^ pl[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    for (int i = 0; i < 24; i++) s[i] = 8'h00;
    s[0] = {sel, cnt};
    s[1] = 8'h00;
    for (int i = 0; i < L; i++) s[2 + i] = pl[i];
    s[L + 2] = c;
    W = (L + 6) / 4;
    e = '0;
    e.araddr = ia;
    e.arlen  = 8'(R - 1);
    e.awaddr = oa;
    e.awlen  = 8'(W - 1);
    e.wn     = W;
    for (int w = 0; w < W; w++) e.w[w] = {s[4*w+3], s[4*w+2], s[4*w+1], s[4*w]};
    e.errs = (rl + 1 != R) ? 1 : 0;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] sel, input logic [3:0] cnt, input logic [31:0] ia,
                               input logic [31:0] oa, input logic [31:0] rw0, input logic [31:0] rw1,
                               input int rl, input int dly, input logic [7:0] arlen,
                               input logic [7:0] awlen, input int wn, input logic [31:0] w0,
                               input logic [31:0] w1, input int errs);
    vec_t v;
    v = '0;
    v.sel = sel; v.cnt = cnt; v.ia = ia; v.oa = oa;
    v.rw[0] = rw0; v.rw[1] = rw1; v.rl = rl; v.dly = dly;
    v.e.araddr = ia; v.e.arlen = arlen; v.e.awaddr = oa; v.e.awlen = awlen;
    v.e.wn = wn; v.e.w[0] = w0; v.e.w[1] = w1; v.e.errs = errs;
    return v;
  endfunction

  task automatic run_txn(input logic [3:0] sel, input logic [3:0] cnt, input logic [31:0] ia,
                         input logic [31:0] oa, input int rl, input int dly, input bit abort);
    int          t, bad;
    logic [31:0] cw;
    logic        cl;
    got_wn = 0; got_wl = '0; got_araddr = '0; got_awaddr = '0; got_arlen = '0; got_awlen = '0;
    for (int i = 0; i < 8; i++) got_w[i] = '0;
    @(negedge clk);
    start = 1'b1; data_sel = sel; byte_cnt = cnt; in_addr = ia; out_addr = oa;
    @(negedge clk);
    start = 1'b0; data_sel = 4'($urandom); byte_cnt = 4'($urandom);
    in_addr = $urandom; out_addr = $urandom;

    t = 0;
    while (!bus.arvalid && t < 50) begin @(negedge clk); t++; end
    chk("arvalid", 64'(bus.arvalid), 64'd1);
    if (!bus.arvalid) return;
    got_araddr = bus.araddr; got_arlen = bus.arlen; bad = 0;
    repeat (dly) begin
      @(negedge clk);
      if (bus.araddr !== got_araddr || bus.arlen !== got_arlen || bus.arvalid !== 1'b1) bad++;
    end
    chk("ar_stable", 64'(bad), 64'd0);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;

    for (int b = 0; b <= rl; b++) begin
      if (dly > 0) begin bus.rvalid = 1'b0; @(negedge clk); end
      bus.rvalid = 1'b1; bus.rdata = rwords[b]; bus.rlast = (b == rl);
      t = 0;
      while (!bus.rready && t < 50) begin @(negedge clk); t++; end
      chk("rready", 64'(bus.rready), 64'd1);
      if (!bus.rready) begin bus.rvalid = 1'b0; return; end
      @(negedge clk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;

    t = 0;
    while (!bus.awvalid && t < 50) begin @(negedge clk); t++; end
    chk("awvalid", 64'(bus.awvalid), 64'd1);
    if (!bus.awvalid) return;
    got_awaddr = bus.awaddr; got_awlen = bus.awlen; bad = 0;
    repeat (dly) begin
      @(negedge clk);
      if (bus.awaddr !== got_awaddr || bus.awlen !== got_awlen || bus.awvalid !== 1'b1) bad++;
    end
    chk("aw_stable", 64'(bad), 64'd0);
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;

    do begin
      t = 0;
      while (!bus.wvalid && t < 50) begin @(negedge clk); t++; end
      chk("wvalid", 64'(bus.wvalid), 64'd1);
      if (!bus.wvalid) return;
      if (abort) begin
        #1 reset = 1'b0;
        #1 chk("abort_outputs", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                                     bus.wlast, bus.bready, busy}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      cw = bus.wdata; cl = bus.wlast; bad = 0;
      repeat (dly) begin
        @(negedge clk);
        if (bus.wdata !== cw || bus.wlast !== cl || bus.wvalid !== 1'b1) bad++;
      end
      chk("w_stable", 64'(bad), 64'd0);
      bus.wready = 1'b1;
      got_w[got_wn] = cw;
      got_wl[got_wn] = cl;
      got_wn++;
      @(negedge clk);
      bus.wready = 1'b0;
    end while (!cl && got_wn < 8);

    repeat (dly) @(negedge clk);
    t = 0;
    while (!bus.bready && t < 50) begin @(negedge clk); t++; end
    chk("bready", 64'(bus.bready), 64'd1);
    bus.bvalid = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic cmp(input exp_t e, input int e0, input int d0);
    chk("araddr", 64'(got_araddr), 64'(e.araddr));
    chk("arlen", 64'(got_arlen), 64'(e.arlen));
    chk("awaddr", 64'(got_awaddr), 64'(e.awaddr));
    chk("awlen", 64'(got_awlen), 64'(e.awlen));
    chk("wbeats", 64'(got_wn), 64'(e.wn));
    for (int i = 0; i < e.wn && i < 5; i++) chk("wdata", 64'(got_w[i]), 64'(e.w[i]));
    chk("wlast_pos", 64'(got_wl), 64'(8'(1 << (e.wn - 1))));
    chk("err_pulses", 64'(err_cnt - e0), 64'(e.errs));
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    vec_t       vecs [4];
    exp_t       e;
    int         e0, d0, av, bs, L, k, R, rl;
    logic [3:0] sel, cnt;

    bus.arready = 1'b0; bus.rdata = '0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    for (int i = 0; i < 32; i++) rwords[i] = '0;

    vecs[0] = mkv(4'd2, 4'd3, 32'h100, 32'h200, 32'h04030201, 32'h0, 0, 0,
                  8'd0, 8'd1, 2, 32'h02010023, 32'h00E30403, 0);
    vecs[1] = mkv(4'd0, 4'd1, 32'h40, 32'h80, 32'hFFFFFF01, 32'hFFFFFF00, 1, 0,
                  8'd1, 8'd1, 2, 32'h00010001, 32'h00000015, 0);
    vecs[2] = mkv(4'd1, 4'd0, 32'h300, 32'h400, 32'h1234BBAA, 32'h0, 0, 1,
                  8'd0, 8'd0, 1, 32'h5FAA0010, 32'h0, 0);
    vecs[3] = mkv(4'd2, 4'd3, 32'h100, 32'h200, 32'h04030201, 32'h0, 0, 3,
                  8'd0, 8'd1, 2, 32'h02010023, 32'h00E30403, 0);

    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", 64'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.wlast,
                         bus.bready, busy, done, err}), 64'd0);
    chk("rst_addr", 64'({bus.araddr, bus.awaddr}), 64'd0);
    chk("rst_len_data", 64'({bus.arlen, bus.awlen, bus.wdata}), 64'd0);
    reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      cur_tag = $sformatf("vec%0d", v);
      for (int b = 0; b < 32; b++) rwords[b] = (b < 4) ? vecs[v].rw[b] : 32'h0;
      e0 = err_cnt; d0 = done_cnt;
      run_txn(vecs[v].sel, vecs[v].cnt, vecs[v].ia, vecs[v].oa, vecs[v].rl, vecs[v].dly, 1'b0);
      cmp(vecs[v].e, e0, d0);
    end

    cur_tag = "illegal_sel";
    e0 = err_cnt; av = 0; bs = 0;
    @(negedge clk);
    start = 1'b1; data_sel = 4'd3; byte_cnt = 4'd5;
    @(negedge clk);
    start = 1'b0; data_sel = 4'd0;
    repeat (8) begin
      if (bus.arvalid || bus.awvalid) av++;
      if (busy) bs++;
      @(negedge clk);
    end
    chk("err_once", 64'(err_cnt - e0), 64'd1);
    chk("no_valid", 64'(av), 64'd0);
    chk("busy_low", 64'(bs), 64'd0);

    cur_tag = "short_read";
    for (int b = 0; b < 32; b++) rwords[b] = $urandom | 32'h01010101;
    e = model(4'd1, 4'd15, 32'h1000, 32'h2000, 3);
    e0 = err_cnt; d0 = done_cnt;
    run_txn(4'd1, 4'd15, 32'h1000, 32'h2000, 3, 1, 1'b0);
    cmp(e, e0, d0);
    chk("pad_zero_b2", 64'(got_w[2][31:16]), 64'd0);
    chk("pad_zero_b3", 64'(got_w[3]), 64'd0);
    chk("pad_zero_b4", 64'({got_w[4][31:24], got_w[4][15:0]}), 64'd0);

    cur_tag = "abort";
    rwords[0] = 32'h04030201;
    d0 = done_cnt;
    run_txn(4'd2, 4'd3, 32'h100, 32'h200, 0, 0, 1'b1);
    @(negedge clk);
    chk("no_done", 64'(done_cnt - d0), 64'd0);
    chk("idle", 64'(busy), 64'd0);

    cur_tag = "after_abort";
    e = model(4'd2, 4'd3, 32'h100, 32'h200, 0);
    e0 = err_cnt; d0 = done_cnt;
    run_txn(4'd2, 4'd3, 32'h100, 32'h200, 0, 0, 1'b0);
    cmp(e, e0, d0);

    for (int it = 0; it < 25; it++) begin
      cur_tag = $sformatf("rand%0d", it);
      sel = 4'($urandom_range(0, 2));
      cnt = 4'($urandom_range(0, 15));
      for (int b = 0; b < 32; b++) rwords[b] = $urandom;
      L = int'(cnt) + 1;
      k = (sel == 4'd0) ? 1 : (sel == 4'd1) ? 2 : 4;
      R = (L + k - 1) / k;
      rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, R)) : R - 1;
      in_addr = $urandom; out_addr = $urandom;
      e = model(sel, cnt, in_addr, out_addr, rl);
      e0 = err_cnt; d0 = done_cnt;
      run_txn(sel, cnt, e.araddr, e.awaddr, rl, int'($urandom_range(0, 3)), 1'b0);
      cmp(e, e0, d0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
